// File: rtl/uart_defs_pkg.sv
// uart_defs_pkg
// Definitions shared by the UART transmitter and receiver:
//   - uart_state_e : receiver/transmitter state encoding (3 bits)
//   - UART_CNT_W   : width of the per-bit clock counter
//   - clks_per_bit : derives clk cycles per line bit from the clock and baud rates
package uart_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_e;

  localparam int UART_CNT_W = 32;

  // Integer divide; the result must be at least 4 for the half-bit
  // centring to leave a usable window.
  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for signals asynchronous to clk.
// Ports:
//   clk_i : system clock, rising edge
//   rst_i : asynchronous active-high reset; both flops load RESET_VAL
//   d_i   : asynchronous input, WIDTH bits
//   q_o   : synchronised output, two clk cycles behind d_i
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
// 8N1 UART receiver: 8 data bits LSB first, no parity, one stop bit.
// The rx line is synchronised, the start bit is validated at its centre,
// and every following bit is sampled one bit period later (its centre).
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset, clears all state
//   rx        : serial line, asynchronous to clk, idle high
//   data_out  : last correctly framed byte, held until the next good frame
//   valid     : one-cycle pulse when data_out updates
//   frame_err : one-cycle pulse when the stop bit samples low
//   busy      : high whenever the receiver is not idle
//
// Latency: valid (or frame_err) is high in the cycle following the
// rising clk edge numbered 2 + 1 + HALF_BIT + 9*CLKS_PER_BIT, counting the
// first rising edge after the rx falling edge as edge 1
// (2 synchroniser edges, 1 edge to leave IDLE, HALF_BIT edges to the
// start-bit centre, then 9 bit periods to the stop-bit centre).
module uart_receiver
  import uart_defs_pkg::*;
#(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  localparam logic [UART_CNT_W-1:0] CNT_HALF_END = UART_CNT_W'(HALF_BIT - 1);
  localparam logic [UART_CNT_W-1:0] CNT_BIT_END  = UART_CNT_W'(CLKS_PER_BIT - 1);

  logic                  rx_s;
  uart_state_e           state_q;
  logic [UART_CNT_W-1:0] cnt_q;
  logic [2:0]            idx_q;
  logic [7:0]            shift_q;
  logic [7:0]            data_q;
  logic                  valid_q;
  logic                  frame_err_q;

  logic [UART_CNT_W-1:0] cnt_d;
  logic [7:0]            shift_d;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // LSB arrives first, so each new bit enters at the top and the byte is
  // aligned after the eighth shift.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    shift_d = {rx_s, shift_q[7:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= ST_START;
          end
        end

        // A line still low at the start-bit centre is a real start bit;
        // anything shorter is treated as a glitch and dropped silently.
        ST_START: begin
          if (cnt_q == CNT_HALF_END) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (rx_s) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_DATA;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ST_DATA: begin
          if (cnt_q == CNT_BIT_END) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        // Leaving at the stop-bit centre gives half a bit of slack, so a
        // start bit immediately following the stop bit is still caught.
        ST_STOP: begin
          if (cnt_q == CNT_BIT_END) begin
            cnt_q <= '0;
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        // A held-low line (break) must not be re-read as a stream of
        // start bits; wait for the line to go idle first.
        ST_WAIT_IDLE: begin
          cnt_q <= '0;
          if (rx_s) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int CLK_F = 1600000;
  localparam int BAUD  = 100000;
  localparam int CPB   = 16;
  localparam int HALF  = CPB / 2;
  // rx falling edge to valid/frame_err, in clk cycles
  localparam int LAT   = 2 + 1 + HALF + 9 * CPB;
  localparam int OPEN  = 1 << 30;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_receiver #(
    .BAUD_RATE  (BAUD),
    .CLOCK_FREQ (CLK_F)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model: expected events keyed by cycle, busy windows, current byte
  logic [7:0] ev_valid[int];
  bit         ev_fe[int];
  int         win_s[$];
  int         win_e[$];
  logic [7:0] mdl_data = 8'h00;
  bit         run = 1'b0;
  bit         e_v, e_f, e_b;

  // Observed pulses
  int         vq[$];
  logic [7:0] dq[$];
  int         fq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit busy_exp(input int c);
    foreach (win_s[i]) if (c >= win_s[i] && c <= win_e[i]) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      if (rst) begin
        mdl_data = 8'h00;
        e_v = 1'b0;
        e_f = 1'b0;
        e_b = 1'b0;
      end else begin
        e_v = ev_valid.exists(cyc);
        if (e_v) mdl_data = ev_valid[cyc];
        e_f = ev_fe.exists(cyc);
        e_b = busy_exp(cyc);
      end
      chk("valid", 32'(valid), 32'(e_v));
      chk("frame_err", 32'(frame_err), 32'(e_f));
      chk("busy", 32'(busy), 32'(e_b));
      chk("data_out", 32'(data_out), 32'(mdl_data));
    end
  end

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vq.push_back(cyc);
      dq.push_back(data_out);
    end
    if (frame_err === 1'b1) fq.push_back(cyc);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called right after a negedge; drives one frame at p clocks per bit
  // and registers the expected outcome with the model.
  task automatic send_frame(input logic [7:0] b, input int p, input logic stop, output int c0);
    c0 = cyc;
    if (stop) begin
      win_s.push_back(c0 + 3);
      win_e.push_back(c0 + LAT - 1);
      ev_valid[c0 + LAT] = b;
    end else begin
      win_s.push_back(c0 + 3);
      win_e.push_back(OPEN);
      ev_fe[c0 + LAT] = 1'b1;
    end
    rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (p) @(negedge clk);
    end
    rx = stop;
    repeat (p) @(negedge clk);
  endtask

  task automatic expect_byte(input string name, input int n0, input int c0, input logic [7:0] b);
    chk({name, "_count"}, 32'(vq.size() - n0), 32'd1);
    if (vq.size() > n0) begin
      chk({name, "_latency"}, 32'(vq[n0] - c0), 32'd155);
      chk({name, "_data"}, 32'(dq[n0]), 32'(b));
    end
  endtask

  initial begin
    int c0, c1, n0, f0, wi;
    rst = 1'b0;
    rx  = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    run = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(10);

    // Single frame
    n0 = vq.size(); f0 = fq.size();
    send_frame(8'hA5, CPB, 1'b1, c0);
    idle(20);
    expect_byte("a5", n0, c0, 8'hA5);
    chk("a5_no_ferr", 32'(fq.size() - f0), 32'd0);

    // Back-to-back, no idle bits
    n0 = vq.size();
    send_frame(8'h00, CPB, 1'b1, c0);
    send_frame(8'hFF, CPB, 1'b1, c1);
    idle(20);
    chk("b2b_count", 32'(vq.size() - n0), 32'd2);
    if (vq.size() >= n0 + 2) begin
      chk("b2b_spacing", 32'(vq[n0+1] - vq[n0]), 32'd160);
      chk("b2b_data0", 32'(dq[n0]), 32'h00);
      chk("b2b_data1", 32'(dq[n0+1]), 32'hFF);
    end

    // 3-cycle glitch: busy for START up to the half-bit sample only
    n0 = vq.size(); f0 = fq.size();
    c0 = cyc;
    win_s.push_back(c0 + 3);
    win_e.push_back(c0 + 3 + HALF - 1);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    chk("glitch_no_valid", 32'(vq.size() - n0), 32'd0);
    chk("glitch_no_ferr", 32'(fq.size() - f0), 32'd0);
    send_frame(8'h3C, CPB, 1'b1, c0);
    idle(20);
    expect_byte("3c", n0, c0, 8'h3C);

    // Stop bit low, line held low 40 more cycles
    n0 = vq.size(); f0 = fq.size();
    send_frame(8'h55, CPB, 1'b0, c0);
    wi = win_s.size() - 1;
    repeat (40) @(negedge clk);
    win_e[wi] = cyc + 2;
    idle(20);
    chk("ferr_count", 32'(fq.size() - f0), 32'd1);
    if (fq.size() > f0) chk("ferr_latency", 32'(fq[f0] - c0), 32'd155);
    chk("ferr_no_valid", 32'(vq.size() - n0), 32'd0);
    chk("ferr_data_kept", 32'(data_out), 32'h3C);
    send_frame(8'h81, CPB, 1'b1, c0);
    idle(20);
    expect_byte("81", n0, c0, 8'h81);

    // Reset during data bit 4 of 0xF0
    n0 = vq.size(); f0 = fq.size();
    c0 = cyc;
    win_s.push_back(c0 + 3);
    win_e.push_back(OPEN);
    wi = win_s.size() - 1;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (HALF) @(negedge clk);
    #2 rst = 1'b1;
    win_e[wi] = cyc;
    #1;
    chk("arst_data_out", 32'(data_out), 32'h00);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_frame_err", 32'(frame_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(40);
    chk("arst_no_valid", 32'(vq.size() - n0), 32'd0);
    chk("arst_no_ferr", 32'(fq.size() - f0), 32'd0);
    send_frame(8'h12, CPB, 1'b1, c0);
    idle(20);
    expect_byte("12", n0, c0, 8'h12);

    // Bit-period tolerance
    n0 = vq.size();
    send_frame(8'hC3, 15, 1'b1, c0);
    idle(30);
    expect_byte("c3_fast", n0, c0, 8'hC3);
    n0 = vq.size();
    send_frame(8'hC3, 17, 1'b1, c0);
    idle(30);
    expect_byte("c3_slow", n0, c0, 8'hC3);

    repeat (5) @(negedge clk);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
